// File: rtl/mem_line_server.sv
// rtl/mem_line_server.sv - main-memory line refill responder with programmable latency
//
// Purpose: accepts one 16-byte line request at a time and returns the line as
// four 32-bit beats over a valid/ready channel, LATENCY cycles after accept.
// Backing store is the internal word array `ram`, preloaded externally and
// never written by this block.
//
// Optional feature macro: MEM_CRITICAL_WORD_FIRST_EN
//   defined   : burst starts at req_addr[3:2] and wraps around the line
//   undefined : burst always starts at word 0
//
// Parameters:
//   DEPTH_WORDS  words in `ram` (power of two, >= 4)
//   LATENCY      cycles from accept to first visible beat (1..15)
//
// Ports:
//   clk          single clock, rising edge
//   reset        synchronous, active-high
//   req_valid    initiator has a line request
//   req_ready    server idle and able to accept
//   req_addr     byte address; line base = req_addr[31:4]
//   resp_valid   resp_data holds a valid beat
//   resp_ready   initiator takes the current beat
//   resp_data    beat data
//   resp_word    word offset within the line of the current beat
//   resp_last    current beat is the fourth of the line

module mem_line_server #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_data,
   output logic [1:0]  resp_word,
   output logic        resp_last
);

   localparam int AW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_BURST = 2'd2
   } state_t;

   logic [31:0] ram [0:DEPTH_WORDS-1];

   state_t      r_state;
   state_t      w_next;
   logic [27:0] r_line;
   logic [1:0]  r_start;
   logic [1:0]  r_beat;
   logic [3:0]  r_count;

   logic        w_accept;
   logic        w_beat_done;
   logic [1:0]  w_start;
   logic [29:0] w_word_addr;

`ifdef MEM_CRITICAL_WORD_FIRST_EN
   assign w_start = req_addr[3:2];
`else
   assign w_start = 2'b00;
`endif

   always_comb begin
      w_next      = r_state;
      req_ready   = 1'b0;
      resp_valid  = 1'b0;
      resp_last   = 1'b0;
      w_accept    = 1'b0;
      w_beat_done = 1'b0;
      case (r_state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               w_accept = 1'b1;
               w_next   = S_WAIT;
            end
         end
         S_WAIT: begin
            if (r_count == 4'd0) begin
               w_next = S_BURST;
            end
         end
         S_BURST: begin
            resp_valid = 1'b1;
            resp_last  = (r_beat == 2'd3);
            if (resp_ready) begin
               w_beat_done = 1'b1;
               if (r_beat == 2'd3) begin
                  w_next = S_IDLE;
               end
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Word offset wraps naturally in two bits; array index keeps only the low
   // address bits, so out-of-range lines alias silently.
   assign resp_word   = r_start + r_beat;
   assign w_word_addr = {r_line, resp_word};
   assign resp_data   = ram[w_word_addr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_line  <= 28'd0;
         r_start <= 2'd0;
         r_beat  <= 2'd0;
         r_count <= 4'd0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_line  <= req_addr[31:4];
            r_start <= w_start;
            r_beat  <= 2'd0;
            r_count <= 4'(LATENCY - 1);
         end
         if (r_state == S_WAIT && r_count != 4'd0) begin
            r_count <= r_count - 4'd1;
         end
         // Beat pointer rolls 3 -> 0 at burst end, ready for the next line.
         if (w_beat_done) begin
            r_beat <= r_beat + 2'd1;
         end
      end
   end

endmodule

// File: tb/tb_mem_line_server.sv
// tb/tb_mem_line_server.sv - randomized self-checking bench for mem_line_server

module tb_mem_line_server;

   localparam int DEPTH = 1024;
   localparam int LAT   = 8;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_data;
   logic [1:0]  resp_word;
   logic        resp_last;

   logic [31:0] exp_ram [0:DEPTH-1];
   int          total;
   int          bad;

   mem_line_server #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .resp_word  (resp_word),
      .resp_last  (resp_last)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: which line word is delivered on beat b of a request.
   function automatic int exp_word(input logic [31:0] addr, input int b);
      int start;
`ifdef MEM_CRITICAL_WORD_FIRST_EN
      start = int'(addr[3:2]);
`else
      start = 0;
`endif
      return (start + b) % 4;
   endfunction

   function automatic int exp_index(input logic [31:0] addr, input int b);
      longint line;
      line = longint'(addr) / 16;
      return int'((line * 4 + longint'(exp_word(addr, b))) % DEPTH);
   endfunction

   // Issue one request at a negedge and follow it to completion.
   // stall_beat 0..3 holds resp_ready low for stall_len cycles on that beat.
   // hold_other keeps req_valid high with a different address throughout.
   task automatic run_req(input logic [31:0] addr, input int stall_beat,
                          input int stall_len, input bit hold_other);
      int n;
      chk("idle_req_ready", req_ready, 1);
      req_valid  = 1'b1;
      req_addr   = addr;
      resp_ready = 1'b1;
      @(negedge clk);
      if (hold_other) req_addr = addr ^ 32'h0000_0500;
      else            req_valid = 1'b0;
      n = 0;
      while (resp_valid !== 1'b1 && n < 40) begin
         chk("wait_req_ready", req_ready, 0);
         @(negedge clk);
         n++;
      end
      chk("latency", n, LAT);
      for (int b = 0; b < 4; b++) begin
         if (b == stall_beat) begin
            resp_ready = 1'b0;
            for (int s = 0; s < stall_len; s++) begin
               chk("stall_valid", resp_valid, 1);
               chk("stall_data",  resp_data, exp_ram[exp_index(addr, b)]);
               chk("stall_word",  resp_word, exp_word(addr, b));
               chk("stall_last",  resp_last, (b == 3));
               @(negedge clk);
            end
            resp_ready = 1'b1;
         end
         chk("beat_valid", resp_valid, 1);
         chk("beat_data",  resp_data, exp_ram[exp_index(addr, b)]);
         chk("beat_word",  resp_word, exp_word(addr, b));
         chk("beat_last",  resp_last, (b == 3));
         chk("beat_req_ready", req_ready, 0);
         @(negedge clk);
      end
      chk("done_req_ready",  req_ready, 1);
      chk("done_resp_valid", resp_valid, 0);
   endtask

   initial begin
      int          n;
      logic [31:0] a;
      int          sb;
      int          sl;
      bit          h;

      total      = 0;
      bad        = 0;
      reset      = 1'b1;
      req_valid  = 1'b0;
      req_addr   = 32'd0;
      resp_ready = 1'b1;

      for (int i = 0; i < DEPTH; i++) begin
         exp_ram[i] = $urandom;
      end
      for (int i = 0; i < 4; i++) begin
         exp_ram[32'h40 + i] = 32'hA0A0_0000 + i;
         exp_ram[32'h80 + i] = 32'hB0B0_0000 + i;
      end
      for (int i = 0; i < DEPTH; i++) begin
         dut.ram[i] = exp_ram[i];
      end

      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("rst_word", resp_word, 0);
      chk("rst_last", resp_last, 0);
      chk("rst_data", resp_data, exp_ram[0]);
      for (int i = 0; i < 20; i++) begin
         chk("idle_ready", req_ready, 1);
         chk("idle_valid", resp_valid, 0);
         @(negedge clk);
      end

      // Directed line fetches, in-order and critical-word addresses.
      run_req(32'h0000_0100, 4, 0, 1'b0);
      run_req(32'h0000_0108, 4, 0, 1'b0);
      // Backpressure on beat 1.
      run_req(32'h0000_0100, 1, 3, 1'b0);
      // req_valid held with a different address: ignored until idle.
      run_req(32'h0000_0104, 4, 0, 1'b1);
      run_req(32'h0000_0104 ^ 32'h0000_0500, 4, 0, 1'b0);

      // Reset during the second beat abandons the line.
      chk("pre_reset_ready", req_ready, 1);
      req_valid = 1'b1;
      req_addr  = 32'h0000_0100;
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      while (resp_valid !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("rst_mid_latency", n, LAT);
      chk("rst_mid_beat0", resp_data, exp_ram[exp_index(32'h0000_0100, 0)]);
      @(negedge clk);
      chk("rst_mid_beat1", resp_data, exp_ram[exp_index(32'h0000_0100, 1)]);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rst_mid_valid", resp_valid, 0);
      chk("rst_mid_ready", req_ready, 1);
      chk("rst_mid_word",  resp_word, 0);
      chk("rst_mid_last",  resp_last, 0);
      chk("rst_mid_data",  resp_data, exp_ram[0]);
      for (int i = 0; i < 12; i++) begin
         chk("rst_mid_quiet", resp_valid, 0);
         @(negedge clk);
      end
      run_req(32'h0000_0200, 4, 0, 1'b0);
      run_req(32'h4000_0000, 4, 0, 1'b0);

      // Reset and request on the same edge: request dropped.
      reset     = 1'b1;
      req_valid = 1'b1;
      req_addr  = 32'h0000_0300;
      @(negedge clk);
      reset     = 1'b0;
      req_valid = 1'b0;
      for (int i = 0; i < 12; i++) begin
         chk("drop_ready", req_ready, 1);
         chk("drop_valid", resp_valid, 0);
         @(negedge clk);
      end

      // Randomized requests against the reference model.
      for (int k = 0; k < 10; k++) begin
         a  = $urandom;
         sb = $urandom_range(0, 4);
         sl = $urandom_range(1, 3);
         h  = 1'($urandom_range(0, 1));
         run_req(a, sb, sl, h);
         if (h) run_req(a ^ 32'h0000_0500, 4, 0, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
